// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch pulse path.
package glitch_pkg;

   // Controller state; encoding is fixed so status decode stays stable.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StDelay = 2'd2,
      StPulse = 2'd3
   } state_e;

   // Edge-select encodings for the trigger qualifier.
   localparam logic EDGE_RISE = 1'b0;
   localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/edge_detect.sv
// Trigger edge qualifier: remembers the previous trigger level every cycle and
// reports the selected transition as a single-cycle combinational pulse.
module edge_detect
   import glitch_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic sel,
   output logic pulse
);

   logic trig_prev_q, trig_prev_d;

   // Previous level tracks the input unconditionally, so a level that is
   // already present when arming never looks like a fresh transition.
   always_comb begin
      trig_prev_d = in;
   end

   // Previous-level register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_prev_q <= 1'b0;
      end else begin
         trig_prev_q <= trig_prev_d;
      end
   end

   // Selected transition decode.
   always_comb begin
      pulse = 1'b0;
      if (sel == EDGE_FALL) begin
         pulse = ~in & trig_prev_q;
      end else begin
         pulse = in & ~trig_prev_q;
      end
   end

endmodule

// File: rtl/glitch_pulse_gen.sv
// Single-shot glitch timing core: waits for a qualified trigger edge while
// armed, counts a programmable delay, then drives one pulse of programmable
// width and flags completion.
module glitch_pulse_gen
   import glitch_pkg::*;
#(
   parameter int unsigned DELAY_W = 16,
   parameter int unsigned WIDTH_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               trig_in,
   input  logic               edge_sel,
   input  logic               arm,
   input  logic               abort,
   input  logic [DELAY_W-1:0] delay,
   input  logic [WIDTH_W-1:0] width,
   output logic               glitch_out,
   output logic               armed,
   output logic               busy,
   output logic               done
);

   state_e               state_q, state_d;
   logic [DELAY_W-1:0]   cnt_q, cnt_d;
   logic [DELAY_W-1:0]   delay_q, delay_d;
   logic [WIDTH_W-1:0]   width_q, width_d;
   logic                 sel_q, sel_d;
   logic                 glitch_q, glitch_d;
   logic                 done_q, done_d;
   logic                 edge_hit;
   logic [DELAY_W-1:0]   width_last;

   edge_detect u_edge_detect (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (trig_in),
      .sel   (sel_q),
      .pulse (edge_hit)
   );

   // width_q is never 0, so the last pulse count cannot underflow.
   assign width_last = DELAY_W'(width_q) - DELAY_W'(1);

   // Next-state, counter and parameter-latch logic; abort overrides all.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      delay_d  = delay_q;
      width_d  = width_q;
      sel_d    = sel_q;
      glitch_d = glitch_q;
      done_d   = 1'b0;

      if (abort) begin
         state_d  = StIdle;
         glitch_d = 1'b0;
         cnt_d    = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (arm) begin
                  sel_d   = edge_sel;
                  delay_d = delay;
                  width_d = (width == '0) ? WIDTH_W'(1) : width;
                  state_d = StArmed;
               end
            end
            StArmed: begin
               if (edge_hit) begin
                  cnt_d   = '0;
                  state_d = StDelay;
               end
            end
            StDelay: begin
               // delay_q fits in the counter, so the compare fires before wrap.
               if (cnt_q == delay_q) begin
                  glitch_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = StPulse;
               end else begin
                  cnt_d = cnt_q + DELAY_W'(1);
               end
            end
            StPulse: begin
               if (cnt_q == width_last) begin
                  glitch_d = 1'b0;
                  done_d   = 1'b1;
                  cnt_d    = '0;
                  state_d  = StIdle;
               end else begin
                  cnt_d = cnt_q + DELAY_W'(1);
               end
            end
         endcase
      end
   end

   // State, counter, latched parameters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         delay_q  <= '0;
         width_q  <= WIDTH_W'(1);
         sel_q    <= EDGE_RISE;
         glitch_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         delay_q  <= delay_d;
         width_q  <= width_d;
         sel_q    <= sel_d;
         glitch_q <= glitch_d;
         done_q   <= done_d;
      end
   end

   // Status outputs decode from state flops only.
   always_comb begin
      glitch_out = glitch_q;
      done       = done_q;
      armed      = (state_q == StArmed);
      busy       = (state_q != StIdle);
   end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Bench for glitch_pulse_gen: a cycle-indexed model predicts pulse start/stop
// times arithmetically from the latched settings, and directed sequences pin
// the model with hand-computed literal checks.
module tb_glitch_pulse_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trig_in = 1'b0;
   logic        edge_sel = 1'b0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] delay = '0;
   logic [7:0]  width = '0;
   logic        glitch_out, armed, busy, done;

   int tests = 0;
   int fails = 0;

   glitch_pulse_gen #(
      .DELAY_W (16),
      .WIDTH_W (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .trig_in    (trig_in),
      .edge_sel   (edge_sel),
      .arm        (arm),
      .abort      (abort),
      .delay      (delay),
      .width      (width),
      .glitch_out (glitch_out),
      .armed      (armed),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: timestamps instead of a state machine.
   longint cyc = 0;
   bit     m_armed = 0, m_trig = 0, m_sel = 0, m_prev = 0, edge_hit;
   longint m_d = 0, m_w = 1, m_start = 0, m_stop = 0, m_done_at = -1;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         m_armed = 0; m_trig = 0; m_prev = 0; m_done_at = -1;
      end else begin
         edge_hit = m_sel ? (!trig_in && m_prev) : (trig_in && !m_prev);
         if (abort) begin
            m_armed = 0; m_trig = 0; m_done_at = -1;
         end else if (m_armed) begin
            if (edge_hit) begin
               m_armed = 0;
               m_trig  = 1;
               m_start = cyc + 1 + m_d;
               m_stop  = m_start + m_w;
            end
         end else if (m_trig) begin
            if (cyc == m_stop) begin
               m_trig    = 0;
               m_done_at = cyc;
            end
         end else if (arm) begin
            m_armed = 1;
            m_sel   = edge_sel;
            m_d     = longint'(delay);
            m_w     = (width == 0) ? 1 : longint'(width);
         end
         m_prev = trig_in;
         #1;
         chk($sformatf("model cyc %0d glitch_out", cyc), glitch_out, (m_trig && cyc >= m_start));
         chk($sformatf("model cyc %0d done", cyc), done, (m_done_at == cyc));
         chk($sformatf("model cyc %0d armed", cyc), armed, m_armed);
         chk($sformatf("model cyc %0d busy", cyc), busy, (m_armed || m_trig));
      end
   end

   task automatic next(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_arm(input logic s, input logic [15:0] d, input logic [7:0] w);
      edge_sel = s;
      delay    = d;
      width    = w;
      arm      = 1'b1;
      next(1);
      arm      = 1'b0;
   endtask

   initial begin
      next(2);
      chk("reset glitch_out", glitch_out, 0);
      chk("reset done", done, 0);
      chk("reset armed", armed, 0);
      chk("reset busy", busy, 0);
      rst_n = 1'b1;
      next(1);

      // Basic rising edge, delay 3, width 2.
      do_arm(1'b0, 16'd3, 8'd2);
      chk("t1 armed", armed, 1);
      next(2);
      trig_in = 1'b1;
      next(1);
      chk("t1 busy after edge", busy, 1);
      next(3);
      chk("t1 E+3 low", glitch_out, 0);
      next(1);
      chk("t1 E+4 high", glitch_out, 1);
      next(1);
      chk("t1 E+5 high", glitch_out, 1);
      next(1);
      chk("t1 E+6 low", glitch_out, 0);
      chk("t1 E+6 done", done, 1);
      chk("t1 E+6 busy", busy, 0);
      next(1);
      chk("t1 E+7 done", done, 0);
      trig_in = 1'b0;
      next(2);

      // Level present at arm is not an edge; delay 0 / width 0.
      trig_in = 1'b1;
      next(2);
      do_arm(1'b0, 16'd0, 8'd0);
      next(4);
      chk("t2 no pulse on level", glitch_out, 0);
      chk("t2 still armed", armed, 1);
      trig_in = 1'b0;
      next(2);
      trig_in = 1'b1;
      next(1);
      next(1);
      chk("t2 E+1 high", glitch_out, 1);
      next(1);
      chk("t2 E+2 low", glitch_out, 0);
      chk("t2 E+2 done", done, 1);
      next(2);

      // Falling edge, maximum delay.
      do_arm(1'b1, 16'hFFFF, 8'd1);
      next(2);
      trig_in = 1'b0;
      next(1);
      next(65535);
      chk("t3 E+65535 low", glitch_out, 0);
      chk("t3 E+65535 busy", busy, 1);
      next(1);
      chk("t3 E+65536 high", glitch_out, 1);
      next(1);
      chk("t3 E+65537 low", glitch_out, 0);
      chk("t3 E+65537 done", done, 1);
      next(2);

      // Aborts in ARMED, DELAY and PULSE; arm with abort in IDLE.
      do_arm(1'b0, 16'd5, 8'd2);
      abort = 1'b1;
      next(1);
      abort = 1'b0;
      chk("t4 abort armed busy", busy, 0);
      do_arm(1'b0, 16'd10, 8'd2);
      trig_in = 1'b1;
      next(3);
      abort = 1'b1;
      next(1);
      abort = 1'b0;
      chk("t4 abort delay busy", busy, 0);
      trig_in = 1'b0;
      next(1);
      do_arm(1'b0, 16'd0, 8'd5);
      trig_in = 1'b1;
      next(2);
      chk("t4 pulse started", glitch_out, 1);
      abort = 1'b1;
      next(1);
      abort = 1'b0;
      chk("t4 abort pulse glitch", glitch_out, 0);
      chk("t4 abort pulse busy", busy, 0);
      trig_in = 1'b0;
      next(1);
      arm   = 1'b1;
      abort = 1'b1;
      next(1);
      arm   = 1'b0;
      abort = 1'b0;
      chk("t4 arm+abort busy", busy, 0);
      next(1);

      // Mid-operation arm/input changes and extra trigger edges are ignored.
      do_arm(1'b0, 16'd4, 8'd3);
      trig_in = 1'b1;
      next(1);
      arm = 1'b1; edge_sel = 1'b1; delay = 16'd0; width = 8'd1; trig_in = 1'b0;
      next(1);
      arm = 1'b0; trig_in = 1'b1;
      next(1);
      trig_in = 1'b0;
      next(2);
      chk("t5 E+4 low", glitch_out, 0);
      next(1);
      chk("t5 E+5 high", glitch_out, 1);
      trig_in = 1'b1;
      next(1);
      trig_in = 1'b0;
      chk("t5 E+6 high", glitch_out, 1);
      next(1);
      chk("t5 E+7 high", glitch_out, 1);
      next(1);
      chk("t5 E+8 low", glitch_out, 0);
      chk("t5 E+8 done", done, 1);
      next(1);
      chk("t5 E+9 done", done, 0);
      chk("t5 E+9 busy", busy, 0);

      // Asynchronous reset in the middle of a pulse.
      do_arm(1'b0, 16'd0, 8'd5);
      trig_in = 1'b1;
      next(3);
      chk("t6 pulse high", glitch_out, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6 async glitch_out", glitch_out, 0);
      next(1);
      rst_n = 1'b1;
      next(1);
      chk("t6 post glitch_out", glitch_out, 0);
      chk("t6 post done", done, 0);
      chk("t6 post armed", armed, 0);
      chk("t6 post busy", busy, 0);
      next(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/glitch_pulse_gen.md
# glitch_pulse_gen

Trigger-qualified pulse generator that sits directly downstream of the input glitch filter. It consumes the filtered trigger level and waits for a selected edge while armed. It then counts a programmable delay and drives a single glitch pulse of programmable width onto the glitch output. It is the single-shot timing core of the glitch path and reports status back to the control logic.

## Interface
- `DELAY_W`, 16: width of the delay field and of the internal counter; `DELAY_W >= WIDTH_W` is required.
- `WIDTH_W`, 8: width of the pulse-width field.
- `clk` in 1: sole clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `trig_in` in 1: filtered trigger level from the glitch filter output; already synchronous to `clk`.
- `edge_sel` in 1: 0 selects a rising edge, 1 selects a falling edge; sampled at arm.
- `arm` in 1: request to arm; honoured only in IDLE.
- `abort` in 1: cancels any operation.
- `delay` in `DELAY_W`: cycles from the qualifying edge to the start of the pulse; sampled at arm.
- `width` in `WIDTH_W`: pulse length in cycles; sampled at arm; 0 is treated as 1.
- `glitch_out` out 1: glitch drive; registered.
- `armed` out 1: state == ARMED.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse on normal completion; registered.

## Operation
- Reset values: state IDLE, `glitch_out`=0, `done`=0, `armed`=0, `busy`=0, `trig_prev`=0, counter 0.
- `trig_prev` registers `trig_in` every cycle in every state.
- A rising edge is `trig_in & ~trig_prev`; a falling edge is `~trig_in & trig_prev`.
- IDLE:
  - `arm`=1 and `abort`=0 → latch `edge_sel`, `delay`, and `width` (clamped to at least 1); go to ARMED.
- ARMED:
  - Selected edge detected → counter cleared; go to DELAY.
  - A level already present at arm never counts as an edge; a fresh transition is required.
- DELAY:
  - counter == `delay_q` → `glitch_out`<=1, counter cleared, go to PULSE.
  - Otherwise counter increments.
- PULSE:
  - counter == `width_q`-1 → `glitch_out`<=0, `done`<=1, go to IDLE.
  - Otherwise counter increments.
- `abort`=1 in any state → next edge: state IDLE, `glitch_out`=0, `done`=0. Abort has priority over arm, edge, and terminal count.
- `arm` outside IDLE is ignored; latched parameters do not change mid-operation.
- Trigger edges during DELAY or PULSE are ignored; there is no retrigger.
- Counter never wraps: the terminal compare always fires before overflow, because `delay_q` ≤ 2^DELAY_W−1.
- `armed` and `busy` are decoded from state flops only, with no input terms.

## Timing
- Arm accepted at posedge A → `armed`=1 after A.
- Qualifying edge sampled at posedge E → `glitch_out` rises at posedge E+1+`delay`.
- `glitch_out` is high for exactly `width_q` cycles; it falls at posedge E+1+`delay`+`width_q`.
- `done` is high for the single cycle following that fall edge; `busy` drops at the same edge.
- Minimum trigger-to-pulse latency is 1 cycle (`delay`=0).
- Re-arm is possible on the cycle `done` is high, since state is already IDLE.
- The upstream filter adds its own latency; it is not compensated here.
- `rst_n` low forces `glitch_out`=0 immediately (asynchronously), including mid-pulse.

## Structure
- Shared package `glitch_pkg` holds:
  - state encoding (2 bits: IDLE=0, ARMED=1, DELAY=2, PULSE=3);
  - edge-select constants `EDGE_RISE`=0 and `EDGE_FALL`=1.
- One sub-module: `edge_detect` (clk, rst_n, in, sel → pulse), which owns `trig_prev` and the rising/falling select.
- The top block holds the FSM, the parameter latches, and the single shared counter.

## Test plan
- Arm with `delay`=3, `width`=2, rising edge; `trig_in` 0→1 sampled at edge 10 → `glitch_out` high at posedges 14–15, low at 16, `done`=1 for one cycle, `busy`=0.
- Arm while `trig_in`=1, rising selected → no pulse until `trig_in` goes 0 then 1; then `delay`=0, `width`=0 gives `glitch_out` high for exactly 1 cycle, one cycle after the edge.
- Falling-edge select, `delay`=0xFFFF, `width`=1 → pulse starts exactly 65536 cycles after the edge; counter does not wrap.
- `abort` asserted in ARMED, in DELAY, and in the second cycle of a 5-cycle PULSE → `glitch_out`=0 and state IDLE next cycle, `done` never asserts; `arm`+`abort` together in IDLE → stays IDLE.
- `arm` pulsed and inputs changed during DELAY; extra `trig_in` edges during PULSE → timing unchanged from the original latched values, exactly one pulse, one `done`.
- `rst_n` dropped mid-PULSE between clock edges → `glitch_out` 0 before the next posedge; after release all outputs are 0 and state is IDLE.
